dot_engine_arbiter: RTL and testbench
=====================================

Name: dot_engine_arbiter

Overview:
- Shares one pipelined dot-product engine (row-by-column, 8-bit elements, ROW_SIZE lanes) among NUM_REQ element-sequencing controllers, so several output-matrix tiles compute concurrently.
- Round-robin arbitration on a valid/ready request interface.
- Issues operands to the engine and tracks requester ownership in an in-order ID FIFO.
- Steers each returned result to its owner, together with the owner's {row,col} tag.

Parameters:
- ROW_SIZE, 3, number of 8-bit elements per row/column vector.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 4, maximum operations outstanding in the engine (1..8); also the ID FIFO depth.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_row  input  NUM_REQ x ROW_SIZE x 8  row-of-A operands, packed per requester.
- req_col  input  NUM_REQ x ROW_SIZE x 8  column-of-B operands.
- req_tag  input  NUM_REQ x 10  {row[4:0], col[4:0]} of the element being computed.
- req_ready  output  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
- eng_valid_in  output  1  operand strobe to the engine.
- eng_row  output  ROW_SIZE x 8  operands to the engine.
- eng_col  output  ROW_SIZE x 8  operands to the engine.
- eng_valid_out  input  1  engine result strobe.
- eng_result  input  8  engine result.
- rsp_valid  output  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_data  output  8  result value.
- rsp_tag  output  10  tag of the issuing request.
- idle  output  1  high when nothing is in flight.
- err_sticky  output  1  set by a result that arrives with no matching issue.

Behaviour:
- Reset (async assert; deassert is synchronised by the top level):
  - eng_valid_in, rsp_valid = 0; eng_row, eng_col, rsp_data, rsp_tag = 0.
  - Priority pointer = 0, inflight count = 0, FIFO empty, idle = 1, err_sticky = 0.
- Arbitration (combinational grant):
  - If inflight + pending issue < MAX_INFLIGHT, grant the first requester i with req_valid[i] high, searching from ptr upward with wrap. Otherwise req_ready = 0.
  - req_ready is one-hot or zero. It may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - On a transfer to i: ptr <= (i+1) mod NUM_REQ. With no transfer, ptr holds.
  - Once asserted, a requester holds req_valid and its operands until it is granted.
- Issue latency: a transfer at cycle T drives eng_valid_in = 1 at T+1, with eng_row/eng_col = the granted operands registered at T.
  - Those operands are held until the next issue.
  - The engine samples operands only on the eng_valid_in cycle.
  - At most one issue per cycle; back-to-back issues are allowed.
- ID FIFO: on each transfer, push {i, req_tag[i]}.
- Response:
  - On eng_valid_out at cycle R with the FIFO non-empty: pop the FIFO, and at R+1 assert rsp_valid[id] = 1 with rsp_data = eng_result and rsp_tag = the popped tag.
  - Responses are in issue order. Requesters cannot backpressure a response.
- Inflight count: +1 on a transfer, -1 on a pop. A simultaneous transfer and pop leaves the count unchanged.
  - The freed slot is usable in the same cycle as the pop, i.e. ready is computed from the post-pop count.
- Spurious result: eng_valid_out with the FIFO empty sets err_sticky (cleared only by reset). No rsp_valid is raised and the count stays at 0; it does not underflow.
- idle = (inflight count == 0) and no issue pending.
- Reset mid-operation: all in-flight IDs are discarded. Late engine results after reset deassert set err_sticky and are dropped.
- Arithmetic:
  - Inflight counter width is clog2(MAX_INFLIGHT+1).
  - FIFO pointers wrap modulo MAX_INFLIGHT.
  - eng_result passes through unmodified; overflow handling belongs to the engine.
- FSM: none beyond the FIFO/counter. Implementation is roughly 150-250 lines.

Test Plan:
- Apply reset mid-cycle, asynchronously, with clock gated → all outputs at reset values immediately; idle=1, req_ready=0.
- ROW_SIZE=3, requester 0 row {1,2,3}, col {4,5,6}, tag 10'h021; behavioural engine with latency 3 → eng_valid_in 1 cycle after the transfer; rsp_valid=4'b0001, rsp_data=32, rsp_tag=10'h021 one cycle after eng_valid_out.
- All 4 requesters hold req_valid continuously (MAX_INFLIGHT=4, engine latency 1) → grant order 0,1,2,3,0,1; each response steered to the correct one-hot bit with the correct tag.
- MAX_INFLIGHT=2, engine latency 6, requester 2 always valid → two issues, then req_ready=0 until eng_valid_out; re-grant in that same cycle with inflight staying at 2.
- eng_valid_out pulsed with the FIFO empty → err_sticky=1 and stays set; rsp_valid remains 0; the following normal request completes correctly.
- Reset asserted with 3 ops in flight, then the engine emits 3 stale results → no rsp_valid; err_sticky=1; idle=1.

Source files
------------

// File: rtl/dot_engine_arbiter_if.sv
`default_nettype none
// ============================================================================
// dot_engine_arbiter_if : requester, engine and response bundle of the arbiter
// Revision 1.0
// ============================================================================
interface dot_engine_arbiter_if #(
   parameter int ROW_SIZE = 3,
   parameter int NUM_REQ  = 4
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0][ROW_SIZE*8-1:0] req_row;
   logic [NUM_REQ-1:0][ROW_SIZE*8-1:0] req_col;
   logic [NUM_REQ-1:0][9:0]            req_tag;
   logic [NUM_REQ-1:0]                 req_ready;
   logic                               eng_valid_in;
   logic [ROW_SIZE*8-1:0]              eng_row;
   logic [ROW_SIZE*8-1:0]              eng_col;
   logic                               eng_valid_out;
   logic [7:0]                         eng_result;
   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [7:0]                         rsp_data;
   logic [9:0]                         rsp_tag;

   // master is the arbiter; slave is the requester/engine environment
   modport master (
      input  req_valid, req_row, req_col, req_tag, eng_valid_out, eng_result,
      output req_ready, eng_valid_in, eng_row, eng_col, rsp_valid, rsp_data, rsp_tag
   );
   modport slave (
      output req_valid, req_row, req_col, req_tag, eng_valid_out, eng_result,
      input  req_ready, eng_valid_in, eng_row, eng_col, rsp_valid, rsp_data, rsp_tag
   );
endinterface
`default_nettype wire

// File: rtl/dot_engine_arbiter.sv
`default_nettype none
// ============================================================================
// dot_engine_arbiter : round-robin sharing of one dot-product engine, in-order result steering
// Revision 1.0
// ============================================================================
module dot_engine_arbiter #(
   parameter int ROW_SIZE     = 3,
   parameter int NUM_REQ      = 4,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   dot_engine_arbiter_if.master bus,
   output logic                 idle,
   output logic                 err_sticky
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int OP_W  = ROW_SIZE * 8;
   localparam int ENT_W = ID_W + 10;

   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_post_pop;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ENT_W-1:0]     fifo_q [MAX_INFLIGHT];
   logic [ENT_W-1:0]     head;
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic                 grant_found;
   logic [ID_W-1:0]      grant_off, grant_idx;
   logic [ID_W:0]        grant_sum;
   logic                 can_accept, xfer, pop;

   logic                 eng_valid_q;
   logic [OP_W-1:0]      eng_row_q, eng_col_q;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [7:0]           rsp_data_q;
   logic [9:0]           rsp_tag_q;
   logic                 err_q;

   // A slot freed by this cycle's pop is immediately reusable
   assign pop          = bus.eng_valid_out && (cnt_q != '0);
   assign cnt_post_pop = cnt_q - CNT_W'(pop);
   assign can_accept   = cnt_post_pop < CNT_W'(MAX_INFLIGHT);

   assign req_dbl = {bus.req_valid, bus.req_valid};
   assign req_rot = NUM_REQ'(req_dbl >> rr_ptr_q);

   always_comb begin
      grant_found = 1'b0;
      grant_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            grant_found = 1'b1;
            grant_off   = ID_W'(k);
         end
      end
   end

   assign grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
   assign grant_idx = (grant_sum >= (ID_W+1)'(NUM_REQ)) ?
                      ID_W'(grant_sum - (ID_W+1)'(NUM_REQ)) : grant_sum[ID_W-1:0];
   assign xfer      = can_accept && grant_found;

   always_comb begin
      bus.req_ready = '0;
      if (xfer) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   assign rr_ptr_d = !xfer ? rr_ptr_q :
                     (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
   assign wr_ptr_d = !xfer ? wr_ptr_q :
                     (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
   assign rd_ptr_d = !pop ? rd_ptr_q :
                     (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
   assign cnt_d    = cnt_post_pop + CNT_W'(xfer);

   assign head        = fifo_q[rd_ptr_q];
   assign rsp_valid_d = pop ? (NUM_REQ'(1) << head[ENT_W-1:10]) : '0;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         eng_valid_q <= 1'b0;
         eng_row_q   <= '0;
         eng_col_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         eng_valid_q <= xfer;
         if (xfer) begin
            eng_row_q <= bus.req_row[grant_idx];
            eng_col_q <= bus.req_col[grant_idx];
         end
         rsp_valid_q <= rsp_valid_d;
         if (pop) begin
            rsp_data_q <= bus.eng_result;
            rsp_tag_q  <= head[9:0];
         end
         // A result with nothing outstanding (including stale ones after reset)
         if (bus.eng_valid_out && (cnt_q == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   // Ownership storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk_in) begin
      if (xfer) begin
         fifo_q[wr_ptr_q] <= {grant_idx, bus.req_tag[grant_idx]};
      end
   end

   assign bus.eng_valid_in = eng_valid_q;
   assign bus.eng_row      = eng_row_q;
   assign bus.eng_col      = eng_col_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_tag      = rsp_tag_q;
   assign idle             = (cnt_q == '0) && !eng_valid_q;
   assign err_sticky       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_dot_engine_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dot_engine_arbiter : directed and random checks against a queue-based model
// Revision 1.0
// ============================================================================
module tb_dot_engine_arbiter;
   localparam int ROW_SIZE     = 3;
   localparam int NUM_REQ      = 4;
   localparam int MAX_INFLIGHT = 4;
   localparam int OP_W         = ROW_SIZE * 8;

   logic clk_in   = 1'b0;
   logic clk_en   = 1'b0;
   logic rst_n_in = 1'b1;
   logic idle, err_sticky;

   dot_engine_arbiter_if #(.ROW_SIZE(ROW_SIZE), .NUM_REQ(NUM_REQ)) bus ();

   dot_engine_arbiter #(
      .ROW_SIZE(ROW_SIZE), .NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus),
      .idle(idle), .err_sticky(err_sticky)
   );

   always begin
      #5;
      if (clk_en) clk_in = ~clk_in;
   end

   int vecs = 0;
   int miscompares = 0;

   // requester stimulus state
   logic [NUM_REQ-1:0]           vld;
   logic [NUM_REQ-1:0][OP_W-1:0] row, col;
   logic [NUM_REQ-1:0][9:0]      tag;
   logic [NUM_REQ-1:0]           arm_mask;
   int                           prob;
   // behavioural engine
   int          eng_lat;
   bit          spur;
   int          eq_due[$];
   logic [7:0]  eq_res[$];
   int          cyc;
   // reference model
   int          m_ptr;
   bit          m_err;
   int          mq_id[$];
   logic [9:0]  mq_tag[$];
   logic [7:0]  mq_res[$];
   logic                e_eng_valid;
   logic [OP_W-1:0]     e_eng_row, e_eng_col;
   logic [NUM_REQ-1:0]  e_rsp_valid;
   logic [7:0]          e_rsp_data;
   logic [9:0]          e_rsp_tag;
   // observation logs
   int                  grant_log[$];
   int                  rsp_count;
   logic [NUM_REQ-1:0]  last_rsp_valid;
   logic [7:0]          last_rsp_data;
   logic [9:0]          last_rsp_tag;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [7:0] dot(input logic [OP_W-1:0] r, input logic [OP_W-1:0] c);
      int acc = 0;
      for (int k = 0; k < ROW_SIZE; k++) acc += int'(r[8*k +: 8]) * int'(c[8*k +: 8]);
      return 8'(acc);
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      m_err = 1'b0;
      mq_id.delete();
      mq_tag.delete();
      mq_res.delete();
      e_eng_valid = 1'b0;
      e_eng_row   = '0;
      e_eng_col   = '0;
      e_rsp_valid = '0;
      e_rsp_data  = '0;
      e_rsp_tag   = '0;
   endtask

   task automatic do_reset(input string name);
      vld = '0;
      bus.req_valid = '0;
      rst_n_in = 1'b0;
      #1;
      check({name, "_eng_valid_in"}, bus.eng_valid_in, 0);
      check({name, "_eng_row"},      bus.eng_row, 0);
      check({name, "_eng_col"},      bus.eng_col, 0);
      check({name, "_rsp_valid"},    bus.rsp_valid, 0);
      check({name, "_rsp_data"},     bus.rsp_data, 0);
      check({name, "_rsp_tag"},      bus.rsp_tag, 0);
      check({name, "_idle"},         idle, 1);
      check({name, "_err_sticky"},   err_sticky, 0);
      check({name, "_req_ready"},    bus.req_ready, 0);
      model_reset();
      #1 rst_n_in = 1'b1;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic cycle();
      int g, j;
      bit pop;
      logic [NUM_REQ-1:0] e_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!vld[i] && arm_mask[i] && ($urandom_range(1, 100) <= prob)) begin
            vld[i] = 1'b1;
            row[i] = OP_W'($urandom);
            col[i] = OP_W'($urandom);
            tag[i] = 10'($urandom);
         end
      end
      bus.req_valid = vld;
      bus.req_row   = row;
      bus.req_col   = col;
      bus.req_tag   = tag;
      bus.eng_valid_out = 1'b0;
      bus.eng_result    = 8'($urandom);
      if (spur) begin
         bus.eng_valid_out = 1'b1;
         spur = 1'b0;
      end else if (eq_due.size() > 0 && eq_due[0] == cyc) begin
         bus.eng_valid_out = 1'b1;
         bus.eng_result    = eq_res.pop_front();
         void'(eq_due.pop_front());
      end
      if (bus.eng_valid_in) begin
         eq_due.push_back(cyc + eng_lat);
         eq_res.push_back(dot(bus.eng_row, bus.eng_col));
      end
      #1;
      check("eng_valid_in", bus.eng_valid_in, e_eng_valid);
      check("eng_row",      bus.eng_row, e_eng_row);
      check("eng_col",      bus.eng_col, e_eng_col);
      check("rsp_valid",    bus.rsp_valid, e_rsp_valid);
      check("rsp_data",     bus.rsp_data, e_rsp_data);
      check("rsp_tag",      bus.rsp_tag, e_rsp_tag);
      check("err_sticky",   err_sticky, m_err);
      check("idle",         idle, (mq_id.size() == 0) && !e_eng_valid);

      pop = bus.eng_valid_out && (mq_id.size() > 0);
      g = -1;
      if (mq_id.size() - int'(pop) < MAX_INFLIGHT) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (g < 0 && vld[j]) g = j;
         end
      end
      e_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
      check("req_ready", bus.req_ready, e_ready);

      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grant_log.push_back(i);
      if (|bus.rsp_valid) begin
         rsp_count++;
         last_rsp_valid = bus.rsp_valid;
         last_rsp_data  = bus.rsp_data;
         last_rsp_tag   = bus.rsp_tag;
      end

      if (pop) begin
         e_rsp_valid = NUM_REQ'(1 << mq_id[0]);
         e_rsp_data  = mq_res.pop_front();
         e_rsp_tag   = mq_tag.pop_front();
         void'(mq_id.pop_front());
      end else begin
         e_rsp_valid = '0;
         if (bus.eng_valid_out) m_err = 1'b1;
      end
      if (g >= 0) begin
         mq_id.push_back(g);
         mq_tag.push_back(tag[g]);
         mq_res.push_back(dot(row[g], col[g]));
         m_ptr       = (g + 1) % NUM_REQ;
         e_eng_valid = 1'b1;
         e_eng_row   = row[g];
         e_eng_col   = col[g];
         vld[g]      = 1'b0;
      end else begin
         e_eng_valid = 1'b0;
      end
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain();
      prob = 0;
      for (int n = 0; n < 80 && (vld != 0 || mq_id.size() != 0 || eq_due.size() != 0); n++)
         cycle();
      check("drain", {vld != 0, mq_id.size() != 0, eq_due.size() != 0}, 0);
      run(2);
   endtask

   int exp_order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      bus.req_valid = '0;
      bus.req_row   = '0;
      bus.req_col   = '0;
      bus.req_tag   = '0;
      bus.eng_valid_out = 1'b0;
      bus.eng_result    = '0;
      vld = '0; row = '0; col = '0; tag = '0;
      arm_mask = '0; prob = 0; eng_lat = 3; spur = 1'b0; cyc = 0;
      rsp_count = 0;
      last_rsp_valid = '0; last_rsp_data = '0; last_rsp_tag = '0;
      model_reset();

      // asynchronous reset while the clock is stopped
      #3 do_reset("por");
      clk_en = 1'b1;
      @(posedge clk_in);
      #1;

      // single dot product, latency-3 engine
      vld[0] = 1'b1;
      row[0] = {8'd3, 8'd2, 8'd1};
      col[0] = {8'd6, 8'd5, 8'd4};
      tag[0] = 10'h021;
      rsp_count = 0;
      run(7);
      check("dot_rsp_count", rsp_count, 1);
      check("dot_rsp_valid", last_rsp_valid, 4'b0001);
      check("dot_rsp_data",  last_rsp_data, 8'd32);
      check("dot_rsp_tag",   last_rsp_tag, 10'h021);

      // spurious engine result, then a normal request from requester 3
      spur = 1'b1;
      rsp_count = 0;
      run(3);
      check("spur_err", err_sticky, 1);
      check("spur_no_rsp", rsp_count, 0);
      vld[3] = 1'b1;
      row[3] = OP_W'($urandom);
      col[3] = OP_W'($urandom);
      tag[3] = 10'h3a5;
      run(6);
      check("after_spur_rsp_count", rsp_count, 1);
      check("after_spur_rsp_valid", last_rsp_valid, 4'b1000);
      check("after_spur_rsp_tag",   last_rsp_tag, 10'h3a5);
      check("after_spur_err_held",  err_sticky, 1);

      // all requesters continuously valid, latency-1 engine
      eng_lat = 1;
      arm_mask = 4'b1111;
      prob = 100;
      grant_log.delete();
      run(6);
      check("rr_grant_count", grant_log.size(), 6);
      for (int k = 0; k < 6; k++)
         check("rr_grant_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
      drain();

      // in-flight cap with a slow engine and one busy requester
      eng_lat = 8;
      arm_mask = 4'b0100;
      prob = 100;
      grant_log.delete();
      run(9);
      check("cap_grants_before_result", grant_log.size(), MAX_INFLIGHT);
      run(1);
      check("cap_regrant_on_result", grant_log.size(), MAX_INFLIGHT + 1);
      drain();

      // reset with three operations in flight; stale results must be dropped
      eng_lat = 3;
      arm_mask = '0;
      for (int i = 0; i < 3; i++) begin
         vld[i] = 1'b1;
         row[i] = OP_W'($urandom);
         col[i] = OP_W'($urandom);
         tag[i] = 10'($urandom);
      end
      run(4);
      check("pre_reset_inflight", eq_due.size(), 3);
      do_reset("midop");
      rsp_count = 0;
      run(6);
      check("stale_no_rsp", rsp_count, 0);
      check("stale_err", err_sticky, 1);
      check("stale_idle", idle, 1);
      check("stale_ready", bus.req_ready, 0);

      // randomized traffic segments
      for (int s = 0; s < 6; s++) begin
         eng_lat  = $urandom_range(1, 6);
         arm_mask = 4'b1111;
         prob     = $urandom_range(20, 90);
         run(60);
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
